// File: rtl/uci_go_parser.sv
// uci_go_parser
// Line parser for the UCI "go" command arriving as an ASCII byte stream.
// Each line is tokenised; the keyword preceding a number selects which field
// the decimal accumulator (acc = acc*10 + digit) is written into. A completed
// "go" line is offered to the search controller on a valid/ready handshake.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_data/in_valid      host byte stream; in_ready = !out_valid
//   wtime..depth          parsed fields, BIN_WIDTH bits each, 0 if absent
//   present[6:0]          bits 0-5 = wtime,btime,winc,binc,movestogo,depth;
//                         bit 6 = infinite
//   out_valid/out_ready   parsed line handshake
//
// Build option: define UCI_GO_SATURATE_EN to clamp an overflowing number to
// all-ones; otherwise the accumulator wraps modulo 2^BIN_WIDTH.
module uci_go_parser #(
  parameter int unsigned BIN_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIN_WIDTH-1:0] wtime,
  output logic [BIN_WIDTH-1:0] btime,
  output logic [BIN_WIDTH-1:0] winc,
  output logic [BIN_WIDTH-1:0] binc,
  output logic [BIN_WIDTH-1:0] movestogo,
  output logic [BIN_WIDTH-1:0] depth,
  output logic [6:0]           present,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [2:0] ST_LINE_START = 3'd0;
  localparam logic [2:0] ST_GO_O       = 3'd1;
  localparam logic [2:0] ST_GO_SEP     = 3'd2;
  localparam logic [2:0] ST_KEYWORD    = 3'd3;
  localparam logic [2:0] ST_NUMBER     = 3'd4;
  localparam logic [2:0] ST_SKIP_LINE  = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  localparam logic [2:0] FLD_NONE = 3'd7;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam int unsigned KW_BYTES = 9;
  localparam int unsigned AW       = BIN_WIDTH + 4;
  localparam logic [AW-1:0] TEN    = AW'(10);
  // Length counter stops at KW_BYTES+1, which can never match a keyword.
  localparam logic [3:0] KW_OVF    = 4'(KW_BYTES + 1);

  logic [2:0]            r_state, w_state_nxt;
  logic [8*KW_BYTES-1:0] r_kw_buf, w_kw_buf_nxt;
  logic [3:0]            r_kw_len, w_kw_len_nxt;
  logic [2:0]            r_fld_idx, w_fld_idx_nxt;
  logic [BIN_WIDTH-1:0]  r_acc, w_acc_nxt;
  logic                  r_has_digit, w_has_digit_nxt;
  logic                  r_bad, w_bad_nxt;
  logic [6:0]            r_present, w_present_nxt;
  logic [BIN_WIDTH-1:0]  r_field [6];

  logic                  w_accept, w_is_lf, w_is_sep, w_is_cr, w_is_digit;
  logic                  w_wr_en, w_clr;
  logic [7:0]            w_digit8;
  logic [AW-1:0]         w_digit, w_mac;
  logic [BIN_WIDTH-1:0]  w_acc_step;
  logic [2:0]            w_kw_idx;
  logic                  w_kw_inf;
  logic                  w_unused_mac_hi;

  assign out_valid  = (r_state == ST_DONE);
  assign in_ready   = ~out_valid;
  assign w_accept   = in_valid & in_ready;
  assign w_is_lf    = (in_data == CH_LF);
  assign w_is_cr    = (in_data == CH_CR);
  assign w_is_sep   = w_is_lf | (in_data == CH_SP);
  assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);

  assign w_digit8 = in_data - 8'h30;
  assign w_digit  = AW'(w_digit8);
  assign w_mac    = ({4'b0000, r_acc} * TEN) + w_digit;

`ifdef UCI_GO_SATURATE_EN
  // Once clamped, acc*10+digit keeps overflowing, so the token stays at all-ones.
  assign w_acc_step = (w_mac[AW-1:BIN_WIDTH] != '0) ? '1 : w_mac[BIN_WIDTH-1:0];
  assign w_unused_mac_hi = 1'b0;
`else
  assign w_acc_step = w_mac[BIN_WIDTH-1:0];
  assign w_unused_mac_hi = ^w_mac[AW-1:BIN_WIDTH];
`endif

  // Keyword match; length is checked so stray leading bytes cannot alias.
  always_comb begin
    w_kw_idx = FLD_NONE;
    w_kw_inf = 1'b0;
    if      (r_kw_len == 4'd5 && r_kw_buf[39:0] == "wtime")     w_kw_idx = 3'd0;
    else if (r_kw_len == 4'd5 && r_kw_buf[39:0] == "btime")     w_kw_idx = 3'd1;
    else if (r_kw_len == 4'd4 && r_kw_buf[31:0] == "winc")      w_kw_idx = 3'd2;
    else if (r_kw_len == 4'd4 && r_kw_buf[31:0] == "binc")      w_kw_idx = 3'd3;
    else if (r_kw_len == 4'd9 && r_kw_buf[71:0] == "movestogo") w_kw_idx = 3'd4;
    else if (r_kw_len == 4'd5 && r_kw_buf[39:0] == "depth")     w_kw_idx = 3'd5;
    else if (r_kw_len == 4'd8 && r_kw_buf[63:0] == "infinite")  w_kw_inf = 1'b1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_kw_buf_nxt    = r_kw_buf;
    w_kw_len_nxt    = r_kw_len;
    w_fld_idx_nxt   = r_fld_idx;
    w_acc_nxt       = r_acc;
    w_has_digit_nxt = r_has_digit;
    w_bad_nxt       = r_bad;
    w_present_nxt   = r_present;
    w_wr_en         = 1'b0;
    w_clr           = 1'b0;

    if (w_accept && !w_is_cr) begin
      case (r_state)
        ST_LINE_START: begin
          if (in_data == "g")  w_state_nxt = ST_GO_O;
          else if (!w_is_lf)   w_state_nxt = ST_SKIP_LINE;
        end
        ST_GO_O: begin
          if (in_data == "o")  w_state_nxt = ST_GO_SEP;
          else if (w_is_lf)    w_state_nxt = ST_LINE_START;
          else                 w_state_nxt = ST_SKIP_LINE;
        end
        ST_GO_SEP: begin
          w_kw_buf_nxt = '0;
          w_kw_len_nxt = '0;
          if (in_data == CH_SP) w_state_nxt = ST_KEYWORD;
          else if (w_is_lf)     w_state_nxt = ST_DONE;
          else                  w_state_nxt = ST_SKIP_LINE;
        end
        ST_KEYWORD: begin
          if (w_is_sep) begin
            w_kw_buf_nxt = '0;
            w_kw_len_nxt = '0;
            if (r_kw_len != '0) begin
              if (w_kw_inf) begin
                w_present_nxt[6] = 1'b1;
              end else begin
                w_fld_idx_nxt   = w_kw_idx;
                w_has_digit_nxt = 1'b0;
                w_bad_nxt       = 1'b0;
                w_state_nxt     = ST_NUMBER;
              end
            end
            if (w_is_lf) w_state_nxt = ST_DONE;
          end else begin
            w_kw_buf_nxt = {r_kw_buf[8*KW_BYTES-9:0], in_data};
            if (r_kw_len != KW_OVF) w_kw_len_nxt = r_kw_len + 4'd1;
          end
        end
        ST_NUMBER: begin
          if (w_is_sep) begin
            if (r_fld_idx != FLD_NONE && r_has_digit && !r_bad) begin
              w_wr_en                  = 1'b1;
              w_present_nxt[r_fld_idx] = 1'b1;
            end
            w_kw_buf_nxt = '0;
            w_kw_len_nxt = '0;
            w_state_nxt  = w_is_lf ? ST_DONE : ST_KEYWORD;
          end else if (w_is_digit) begin
            w_has_digit_nxt = 1'b1;
            w_acc_nxt       = r_has_digit ? w_acc_step : w_digit[BIN_WIDTH-1:0];
          end else begin
            w_bad_nxt = 1'b1;
          end
        end
        ST_SKIP_LINE: begin
          if (w_is_lf) w_state_nxt = ST_LINE_START;
        end
        default: ;
      endcase
    end

    if (r_state == ST_DONE && out_ready) begin
      w_clr         = 1'b1;
      w_present_nxt = '0;
      w_state_nxt   = ST_LINE_START;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_LINE_START;
      r_kw_buf    <= '0;
      r_kw_len    <= '0;
      r_fld_idx   <= FLD_NONE;
      r_acc       <= '0;
      r_has_digit <= 1'b0;
      r_bad       <= 1'b0;
      r_present   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_kw_buf    <= w_kw_buf_nxt;
      r_kw_len    <= w_kw_len_nxt;
      r_fld_idx   <= w_fld_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_has_digit <= w_has_digit_nxt;
      r_bad       <= w_bad_nxt;
      r_present   <= w_present_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) r_field[i] <= '0;
    end else if (w_clr) begin
      for (int i = 0; i < 6; i++) r_field[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_wr_en && r_fld_idx == 3'(i)) r_field[i] <= r_acc;
      end
    end
  end

  assign wtime     = r_field[0];
  assign btime     = r_field[1];
  assign winc      = r_field[2];
  assign binc      = r_field[3];
  assign movestogo = r_field[4];
  assign depth     = r_field[5];
  assign present   = r_present;

endmodule

// File: tb/tb_uci_go_parser.sv
// Directed bench for uci_go_parser: drives ASCII lines, checks parsed fields,
// presence mask and the output handshake against hand-computed values.
module tb_uci_go_parser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] wtime, btime, winc, binc, movestogo, depth;
  logic [6:0]  present;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uci_go_parser #(.BIN_WIDTH(24)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wtime     (wtime),
    .btime     (btime),
    .winc      (winc),
    .binc      (binc),
    .movestogo (movestogo),
    .depth     (depth),
    .present   (present),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_byte_ready: in_ready=%0b required 1", in_ready);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (present !== 7'h00) $display("FAIL reset_present: got %h want 00", present);
    else n_pass++;
    n_checks++;
    if ({wtime, btime, winc, binc, movestogo, depth} !== 144'h0)
      $display("FAIL reset_fields: got %h want 0", {wtime, btime, winc, binc, movestogo, depth});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_clock_line();
    send_line("go wtime 300000 btime 299000 winc 2000 binc 2000");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL clock_early_valid: got %0b want 0", out_valid);
    else n_pass++;
    send_byte(8'h0A);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL clock_valid: got %0b want 1", out_valid);
    else n_pass++;
    n_checks++;
    if (wtime !== 24'd300000) $display("FAIL clock_wtime: got %0d want 300000", wtime);
    else n_pass++;
    n_checks++;
    if (btime !== 24'd299000) $display("FAIL clock_btime: got %0d want 299000", btime);
    else n_pass++;
    n_checks++;
    if (winc !== 24'd2000 || binc !== 24'd2000)
      $display("FAIL clock_inc: got winc=%0d binc=%0d want 2000/2000", winc, binc);
    else n_pass++;
    n_checks++;
    if (present !== 7'h0F) $display("FAIL clock_present: got %h want 0f", present);
    else n_pass++;
    consume();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || present !== 7'h00 || wtime !== 24'd0)
      $display("FAIL clock_clear: got valid=%0b present=%h wtime=%0d want 0/00/0",
               out_valid, present, wtime);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    send_line("go depth 7 depth 12\n");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || depth !== 24'd12 || present !== 7'h20)
        $display("FAIL hold_cycle%0d: got in_ready=%0b valid=%0b depth=%0d present=%h want 0/1/12/20",
                 c, in_ready, out_valid, depth, present);
      else n_pass++;
    end
    consume();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL hold_release: in_ready got %0b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_skip_infinite();
    send_line("isready\n");
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL skip_valid: got %0b want 0", out_valid);
    else n_pass++;
    send_line("go infinite\n");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || present !== 7'h40)
      $display("FAIL infinite: got valid=%0b present=%h want 1/40", out_valid, present);
    else n_pass++;
    n_checks++;
    if ({wtime, btime, winc, binc, movestogo, depth} !== 144'h0)
      $display("FAIL infinite_fields: got %h want 0", {wtime, btime, winc, binc, movestogo, depth});
    else n_pass++;
    consume();
  endtask

  task automatic test_bad_token();
    send_line("go movestogo 4x0 foo 55 winc 10\n");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || present !== 7'h04)
      $display("FAIL bad_present: got valid=%0b present=%h want 1/04", out_valid, present);
    else n_pass++;
    n_checks++;
    if (movestogo !== 24'd0 || winc !== 24'd10)
      $display("FAIL bad_fields: got movestogo=%0d winc=%0d want 0/10", movestogo, winc);
    else n_pass++;
    consume();
  endtask

  task automatic test_overflow();
    logic [23:0] exp_w;
`ifdef UCI_GO_SATURATE_EN
    exp_w = 24'hFFFFFF;
`else
    exp_w = 24'hF5E0FF;
`endif
    send_line("go wtime 99999999\n");
    @(negedge clk);
    n_checks++;
    if (wtime !== exp_w || present !== 7'h01)
      $display("FAIL overflow: got wtime=%h present=%h want %h/01", wtime, present, exp_w);
    else n_pass++;
    consume();
  endtask

  task automatic test_cr_and_empty();
    send_line("\r\ngo\r\n");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || present !== 7'h00)
      $display("FAIL empty_go: got valid=%0b present=%h want 1/00", out_valid, present);
    else n_pass++;
    consume();
    send_line("go winc 7\r\n");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || winc !== 24'd7 || present !== 7'h04)
      $display("FAIL cr_winc: got valid=%0b winc=%0d present=%h want 1/7/04",
               out_valid, winc, present);
    else n_pass++;
    consume();
  endtask

  task automatic test_reset_midline();
    send_line("go wtime 5 wti");
    @(negedge clk);
    n_checks++;
    if (wtime !== 24'd5) $display("FAIL midline_pre: wtime got %0d want 5", wtime);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (wtime !== 24'd0 || present !== 7'h00 || out_valid !== 1'b0)
      $display("FAIL midline_reset: got wtime=%0d present=%h valid=%0b want 0/00/0",
               wtime, present, out_valid);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    send_line("go binc 5\n");
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || binc !== 24'd5 || present !== 7'h08)
      $display("FAIL midline_next: got valid=%0b binc=%0d present=%h want 1/5/08",
               out_valid, binc, present);
    else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_clock_line();
    test_backpressure();
    test_skip_infinite();
    test_bad_token();
    test_overflow();
    test_cr_and_empty();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
